ltc2333_scan_scheduler: RTL and testbench

Conversion scheduler for the LTC2333 write path. It turns a start command plus scan parameters into a timed stream of 8-bit SoftSpan configuration words, one per active channel, emitted once per sample period. The word stream is handed to the serializer over a valid/ready handshake. The block sits between the IPIF parameter registers (clock-converted into `clk`) and the serializer, and it generates the read-in-progress status.

---
 rtl/ltc2333_scan_scheduler.sv | 154 +++++++++++++++
 tb/tb_ltc2333_scan_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2333_scan_scheduler.sv
// LTC2333 scan scheduler: converts a start command plus scan parameters into
// a periodic stream of 8-bit SoftSpan configuration words, one per active
// channel, handed to the serializer over a valid/ready handshake.
module ltc2333_scan_scheduler #(
  parameter int N_CH     = 8,
  parameter int PERIOD_W = 32,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [N_CH-1:0]     active_channels,
  input  logic [2:0]          range,
  input  logic [PERIOD_W-1:0] sample_period,
  input  logic [COUNT_W-1:0]  n_reads,
  output logic                cfg_valid,
  input  logic                cfg_ready,
  output logic [7:0]          cfg_word,
  output logic                cfg_last,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic [COUNT_W-1:0]  scan_count
);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT} state_t;

  state_t              state_reg;
  logic [N_CH-1:0]     mask_reg;
  logic [2:0]          range_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic [COUNT_W-1:0]  nreads_reg;
  logic [PERIOD_W-1:0] cnt_reg;
  logic [2:0]          ch_reg;

  // Returns {found, index} of the lowest set mask bit at or above 'lo'.
  function automatic logic [3:0] find_active(input logic [N_CH-1:0] m, input int lo);
    logic [3:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Channel look-ups: first channel of a new scan (from inputs at start or
  // from the latched mask on a tick), the next channel after the current
  // one, and for each candidate whether a further channel follows it.
  logic [3:0] first_in, first_in_nx;
  logic [3:0] first_lat, first_lat_nx;
  logic [3:0] nxt, nxt_nx;

  assign first_in     = find_active(active_channels, 0);
  assign first_in_nx  = find_active(active_channels, int'(first_in[2:0]) + 1);
  assign first_lat    = find_active(mask_reg, 0);
  assign first_lat_nx = find_active(mask_reg, int'(first_lat[2:0]) + 1);
  assign nxt          = find_active(mask_reg, int'(ch_reg) + 1);
  assign nxt_nx       = find_active(mask_reg, int'(nxt[2:0]) + 1);

  logic                tick;
  logic                hs;
  logic [COUNT_W-1:0]  scan_count_inc;
  logic [PERIOD_W-1:0] p_eff;

  assign tick           = busy && (cnt_reg == period_reg - PERIOD_W'(1));
  assign hs             = cfg_valid && cfg_ready;
  assign scan_count_inc = (scan_count == '1) ? scan_count : scan_count + COUNT_W'(1);
  assign p_eff          = (sample_period == '0) ? PERIOD_W'(1) : sample_period;

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      mask_reg   <= '0;
      range_reg  <= '0;
      period_reg <= PERIOD_W'(1);
      nreads_reg <= '0;
      cnt_reg    <= '0;
      ch_reg     <= '0;
      cfg_valid  <= 1'b0;
      cfg_word   <= '0;
      cfg_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      scan_count <= '0;
    end else begin
      done <= 1'b0;
      if (busy) cnt_reg <= tick ? '0 : cnt_reg + PERIOD_W'(1);

      if (abort) begin
        // Withdraw any pending word; counters and overrun keep their values.
        state_reg <= IDLE;
        busy      <= 1'b0;
        cfg_valid <= 1'b0;
        cfg_last  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && (active_channels != '0)) begin
              mask_reg   <= active_channels;
              range_reg  <= range;
              period_reg <= p_eff;
              nreads_reg <= n_reads;
              cnt_reg    <= '0;
              scan_count <= '0;
              overrun    <= 1'b0;
              ch_reg     <= first_in[2:0];
              cfg_word   <= {2'b10, first_in[2:0], range};
              cfg_last   <= ~first_in_nx[3];
              cfg_valid  <= 1'b1;
              busy       <= 1'b1;
              state_reg  <= SCAN;
            end
          end
          SCAN: begin
            // A tick during a scan is dropped and flagged.
            if (tick) overrun <= 1'b1;
            if (hs) begin
              if (!cfg_last) begin
                ch_reg   <= nxt[2:0];
                cfg_word <= {2'b10, nxt[2:0], range_reg};
                cfg_last <= ~nxt_nx[3];
              end else begin
                scan_count <= scan_count_inc;
                cfg_valid  <= 1'b0;
                cfg_last   <= 1'b0;
                if ((nreads_reg != '0) && (scan_count_inc == nreads_reg)) begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
                end else begin
                  state_reg <= WAIT;
                end
              end
            end
          end
          WAIT: begin
            if (tick) begin
              ch_reg    <= first_lat[2:0];
              cfg_word  <= {2'b10, first_lat[2:0], range_reg};
              cfg_last  <= ~first_lat_nx[3];
              cfg_valid <= 1'b1;
              state_reg <= SCAN;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ltc2333_scan_scheduler.sv
// Self-checking bench for ltc2333_scan_scheduler: table of single-scan
// vectors plus hand-written multi-cycle sequences.
module tb_ltc2333_scan_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  active_channels = '0;
  logic [2:0]  range_i = '0;
  logic [31:0] sample_period = '0;
  logic [15:0] n_reads = '0;
  logic        cfg_valid;
  logic        cfg_ready = 1'b0;
  logic [7:0]  cfg_word;
  logic        cfg_last;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [15:0] scan_count;

  int checks = 0;
  int errors = 0;

  ltc2333_scan_scheduler #(.N_CH(8), .PERIOD_W(32), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .active_channels(active_channels), .range(range_i),
    .sample_period(sample_period), .n_reads(n_reads),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_word(cfg_word),
    .cfg_last(cfg_last), .busy(busy), .done(done), .overrun(overrun),
    .scan_count(scan_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mask;
    logic [2:0] rng;
    logic [7:0] first_word;
    logic [7:0] last_word;
    int         nwords;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issues a start in the current cycle (cycle 0); returns at cycle 1.
  task automatic start_scan(input logic [7:0] m, input logic [2:0] r,
                            input logic [31:0] p, input logic [15:0] n);
    active_channels = m;
    range_i = r;
    sample_period = p;
    n_reads = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    logic [7:0] w2[4];
    int hs_cnt;
    int done_seen;

    vecs[0] = '{8'h01, 3'd0, 8'h80, 8'h80, 1};
    vecs[1] = '{8'h80, 3'd5, 8'hBD, 8'hBD, 1};
    vecs[2] = '{8'hFF, 3'd2, 8'h82, 8'hBA, 8};
    vecs[3] = '{8'h18, 3'd1, 8'h99, 8'hA1, 2};
    vecs[4] = '{8'h42, 3'd4, 8'h8C, 8'hB4, 2};

    // Reset values
    step();
    step();
    chk("rst_valid", 32'(cfg_valid), 0);
    chk("rst_word", 32'(cfg_word), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_scan_count", 32'(scan_count), 0);
    reset = 1'b0;
    step();

    // Table: single scans with n_reads=1, ready held high
    cfg_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      start_scan(vecs[v].mask, vecs[v].rng, 32'd50, 16'd1);
      for (int k = 1; k <= vecs[v].nwords; k++) begin
        chk($sformatf("v%0d_valid%0d", v, k), 32'(cfg_valid), 1);
        chk($sformatf("v%0d_last%0d", v, k), 32'(cfg_last), 32'(k == vecs[v].nwords));
        if (k == 1) chk($sformatf("v%0d_first", v), 32'(cfg_word), 32'(vecs[v].first_word));
        if (k == vecs[v].nwords) chk($sformatf("v%0d_lastword", v), 32'(cfg_word), 32'(vecs[v].last_word));
        step();
      end
      chk($sformatf("v%0d_done", v), 32'(done), 1);
      chk($sformatf("v%0d_busy", v), 32'(busy), 0);
      chk($sformatf("v%0d_count", v), 32'(scan_count), 1);
      step();
      chk($sformatf("v%0d_done_pulse", v), 32'(done), 0);
    end

    // Two scans of mask A5, P=20: words at 1..4 and 21..24, done at 25
    w2[0] = 8'h87; w2[1] = 8'h97; w2[2] = 8'hAF; w2[3] = 8'hBF;
    start_scan(8'hA5, 3'b111, 32'd20, 16'd2);
    for (int c = 1; c <= 26; c++) begin
      automatic bit in_scan = (c >= 1 && c <= 4) || (c >= 21 && c <= 24);
      chk($sformatf("a5_valid_c%0d", c), 32'(cfg_valid), 32'(in_scan));
      if (in_scan) begin
        chk($sformatf("a5_word_c%0d", c), 32'(cfg_word), 32'(w2[(c - 1) % 20]));
        chk($sformatf("a5_last_c%0d", c), 32'(cfg_last), 32'(c == 4 || c == 24));
      end
      chk($sformatf("a5_done_c%0d", c), 32'(done), 32'(c == 25));
      chk($sformatf("a5_busy_c%0d", c), 32'(busy), 32'(c <= 24));
      if (c == 25) chk("a5_scan_count", 32'(scan_count), 2);
      step();
    end

    // Back-pressure with P=4: word held, overrun, dropped ticks
    cfg_ready = 1'b0;
    start_scan(8'h01, 3'd0, 32'd4, 16'd0);
    for (int c = 1; c <= 13; c++) begin
      cfg_ready = (c >= 11);
      if (c <= 11) begin
        chk($sformatf("bp_valid_c%0d", c), 32'(cfg_valid), 1);
        chk($sformatf("bp_word_c%0d", c), 32'(cfg_word), 32'h80);
      end
      chk($sformatf("bp_overrun_c%0d", c), 32'(overrun), 32'(c >= 5));
      if (c == 12) begin
        chk("bp_gap_valid", 32'(cfg_valid), 0);
        chk("bp_count", 32'(scan_count), 1);
      end
      if (c == 13) chk("bp_next_valid", 32'(cfg_valid), 1);
      step();
    end
    do_abort();
    chk("bp_abort_busy", 32'(busy), 0);

    // Continuous mode, P=10, abort at cycle 57
    cfg_ready = 1'b1;
    hs_cnt = 0;
    done_seen = 0;
    start_scan(8'h03, 3'd1, 32'd10, 16'd0);
    for (int c = 1; c <= 58; c++) begin
      if (cfg_valid && cfg_ready) hs_cnt++;
      if (done) done_seen++;
      abort = (c == 57);
      step();
    end
    abort = 1'b0;
    chk("cont_busy58", 32'(busy), 0);
    chk("cont_valid58", 32'(cfg_valid), 0);
    chk("cont_scan_count", 32'(scan_count), 6);
    chk("cont_handshakes", 32'(hs_cnt), 12);
    chk("cont_no_done", 32'(done_seen + int'(done)), 0);

    // Start with empty mask is ignored
    start_scan(8'h00, 3'd1, 32'd10, 16'd1);
    chk("mask0_busy", 32'(busy), 0);
    chk("mask0_valid", 32'(cfg_valid), 0);
    step();
    chk("mask0_done", 32'(done), 0);

    // Start and abort together: abort wins
    abort = 1'b1;
    start_scan(8'h01, 3'd1, 32'd10, 16'd1);
    abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);
    chk("sa_valid", 32'(cfg_valid), 0);

    // Start while busy leaves parameters unchanged
    cfg_ready = 1'b0;
    start_scan(8'h01, 3'd3, 32'd100, 16'd1);
    chk("sb_word1", 32'(cfg_word), 32'h83);
    start_scan(8'h80, 3'd5, 32'd7, 16'd3);
    chk("sb_word2", 32'(cfg_word), 32'h83);
    chk("sb_busy", 32'(busy), 1);
    step();
    cfg_ready = 1'b1;
    step();
    chk("sb_done", 32'(done), 1);
    chk("sb_count", 32'(scan_count), 1);

    // sample_period=0 acts as P=1: tick every cycle collides with the scan
    start_scan(8'h03, 3'd0, 32'd0, 16'd0);
    chk("p0_overrun_c1", 32'(overrun), 0);
    chk("p0_word_c1", 32'(cfg_word), 32'h80);
    step();
    chk("p0_overrun_c2", 32'(overrun), 1);
    chk("p0_word_c2", 32'(cfg_word), 32'h88);
    do_abort();
    chk("p0_abort_busy", 32'(busy), 0);
    chk("p0_overrun_hold", 32'(overrun), 1);

    // Asynchronous reset in the middle of a stalled scan
    cfg_ready = 1'b0;
    start_scan(8'h0F, 3'd2, 32'd30, 16'd0);
    step();
    chk("ar_pre_valid", 32'(cfg_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(cfg_valid), 0);
    chk("ar_word", 32'(cfg_word), 0);
    chk("ar_last", 32'(cfg_last), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_overrun", 32'(overrun), 0);
    chk("ar_count", 32'(scan_count), 0);
    step();
    reset = 1'b0;
    step();
    step();
    step();
    chk("ar_idle_busy", 32'(busy), 0);
    chk("ar_idle_valid", 32'(cfg_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
